// File: rtl/uart_mmio.sv
// ---------------------------------------------------------------------------
// uart_mmio -- memory-mapped 8N1 UART peripheral (MMIO window offsets 0..7).
//
// The memory controller decodes the UART window and drives the register
// strobes below. Transmit and receive bytes are buffered in FIFO_DEPTH-entry
// FIFOs. A single programmable divisor (clk cycles per bit) times both
// directions.
//
// Ports:
//   clk              system clock
//   rst              synchronous reset, active-high
//   tx_wen           register write strobe
//   rx_ren           register read strobe (a write in the same cycle wins)
//   uart_addr[2:0]   register offset
//   uart_din[7:0]    write data
//   uart_dout[7:0]   read data, combinational from uart_addr and state
//   rx_data_present  RX FIFO not empty
//   tx_full          TX FIFO full
//   rxd              serial input, idle high, asynchronous to clk
//   txd              serial output, idle high
//   irq              (only with UART_MMIO_IRQ_EN) registered interrupt
//
// Register map:
//   0 DATA    W: push TX FIFO (dropped if full)  R: pop RX FIFO head (0 if empty)
//   1 STATUS  R: {3'b0, rx_overrun, tx_busy, tx_empty, tx_full, rx_data_present}
//             a read clears rx_overrun
//   2 DIV_LO, 3 DIV_HI  divisor bytes; a write restarts both baud counters
//   4 IER     (only with UART_MMIO_IRQ_EN) bit0 RX-data enable, bit1 TX-empty
//   others    read 0x00, writes ignored
//
// Optional feature macro: UART_MMIO_IRQ_EN (adds irq output and IER register).
// ---------------------------------------------------------------------------

// Byte FIFO with extra pointer MSB so full and empty are exact.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module uart_mmio_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers update with non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are
    // valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

module uart_mmio #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_wen,
    input  logic       rx_ren,
    input  logic [2:0] uart_addr,
    input  logic [7:0] uart_din,
    output logic [7:0] uart_dout,
    output logic       rx_data_present,
    output logic       tx_full,
    input  logic       rxd,
    output logic       txd
`ifdef UART_MMIO_IRQ_EN
    ,
    output logic       irq
`endif
);
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_DIV_LO = 3'd2;
    localparam logic [2:0] ADDR_DIV_HI = 3'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;   // framing error: wait for line high

    // ---------------- register access decode ----------------
    logic        rd_en;
    logic        div_wr;
    logic        tx_push;
    logic        rx_pop;
    logic [15:0] div;
    logic [15:0] eff_div;
    logic [15:0] half_div;

    assign rd_en   = rx_ren && !tx_wen;   // simultaneous write wins
    assign div_wr  = tx_wen && (uart_addr == ADDR_DIV_LO || uart_addr == ADDR_DIV_HI);
    assign tx_push = tx_wen && (uart_addr == ADDR_DATA) && !tx_full;
    assign rx_pop  = rd_en && (uart_addr == ADDR_DATA);

    assign eff_div  = (div < 16'd2) ? 16'd2 : div;
    assign half_div = eff_div >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= 16'(DEFAULT_DIV);
        end else if (tx_wen) begin
            if (uart_addr == ADDR_DIV_LO) div[7:0]  <= uart_din;
            if (uart_addr == ADDR_DIV_HI) div[15:8] <= uart_din;
        end
    end

    // ---------------- FIFOs ----------------
    logic       tx_empty;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_push;
    logic [7:0] rx_head;
    logic [7:0] rx_shift;

    uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (uart_din),
        .pop   (tx_pop),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_shift),
        .pop   (rx_pop),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign rx_data_present = !rx_empty;

    // ---------------- transmitter ----------------
    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_tick;
    logic        tx_busy;

    assign tx_tick = (tx_cnt == eff_div - 16'd1);
    assign tx_busy = (tx_state != TX_IDLE);
    // Pop when starting from idle, or at the end of a stop bit so the next
    // frame follows with no idle gap.
    assign tx_pop  = !tx_empty &&
                     ((tx_state == TX_IDLE) ||
                      (tx_state == TX_STOP && tx_tick && !div_wr));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            if (!tx_empty) begin
                tx_state <= TX_START;
                tx_shift <= tx_head;
                tx_cnt   <= '0;
                txd      <= 1'b0;
            end
        end else if (div_wr) begin
            tx_cnt <= '0;
        end else if (!tx_tick) begin
            tx_cnt <= tx_cnt + 16'd1;
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                TX_START: begin
                    tx_state <= TX_DATA;
                    tx_bit   <= 3'd0;
                    txd      <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                end
                TX_DATA: begin
                    if (tx_bit == 3'd7) begin
                        tx_state <= TX_STOP;
                        txd      <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end
                end
                default: begin
                    if (!tx_empty) begin
                        tx_state <= TX_START;
                        tx_shift <= tx_head;
                        txd      <= 1'b0;
                    end else begin
                        tx_state <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic        rxd_s1;
    logic        rxd_s2;
    logic        rxd_prev;
    logic        rx_fall;
    logic [2:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic        rx_tick;
    logic        rx_overrun;

    assign rx_fall = rxd_prev && !rxd_s2;
    // START only waits half a bit so later samples land near bit centres.
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == half_div - 16'd1)
                                            : (rx_cnt == eff_div - 16'd1);
    assign rx_push = (rx_state == RX_STOP) && rx_tick && !div_wr && rxd_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rxd_s1   <= rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            if (rx_state == RX_IDLE) begin
                if (rx_fall) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                end
            end else if (rx_state == RX_WAIT) begin
                if (rxd_s2) rx_state <= RX_IDLE;
            end else if (div_wr) begin
                rx_cnt <= '0;
            end else if (!rx_tick) begin
                rx_cnt <= rx_cnt + 16'd1;
            end else begin
                rx_cnt <= '0;
                case (rx_state)
                    RX_START: begin
                        rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
                        rx_bit   <= 3'd0;
                    end
                    RX_DATA: begin
                        rx_shift <= {rxd_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end
                    default: begin
                        rx_state <= rxd_s2 ? RX_IDLE : RX_WAIT;
                    end
                endcase
            end
        end
    end

    // Overrun only when the byte is really lost: a same-edge pop frees a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun <= 1'b0;
        end else if (rx_push && rx_full && !(rx_pop && !rx_empty)) begin
            rx_overrun <= 1'b1;
        end else if (rd_en && uart_addr == ADDR_STATUS) begin
            rx_overrun <= 1'b0;
        end
    end

    // ---------------- optional interrupt ----------------
`ifdef UART_MMIO_IRQ_EN
    localparam logic [2:0] ADDR_IER = 3'd4;
    logic [1:0] ier;

    always_ff @(posedge clk) begin
        if (rst) begin
            ier <= 2'b00;
            irq <= 1'b0;
        end else begin
            if (tx_wen && uart_addr == ADDR_IER) ier <= uart_din[1:0];
            irq <= (ier[0] & rx_data_present) | (ier[1] & tx_empty & ~tx_busy);
        end
    end
`endif

    // ---------------- read mux ----------------
    // NOTE: combinational logic uses blocking '=' and assigns a default first,
    // so no path leaves the output unassigned and no latch is inferred.
    always_comb begin
        uart_dout = 8'h00;
        case (uart_addr)
            ADDR_DATA:   if (!rx_empty) uart_dout = rx_head;
            ADDR_STATUS: uart_dout = {3'b000, rx_overrun, tx_busy, tx_empty, tx_full, rx_data_present};
            ADDR_DIV_LO: uart_dout = div[7:0];
            ADDR_DIV_HI: uart_dout = div[15:8];
`ifdef UART_MMIO_IRQ_EN
            ADDR_IER:    uart_dout = {6'b000000, ier};
`endif
            default:     uart_dout = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio (default build, FIFO_DEPTH=16).
// Expected serial waveforms are built from the 8N1 frame definition; the
// receive side is modelled with a byte queue and an overrun flag.
module tb_uart_mmio;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_wen = 1'b0;
    logic       rx_ren = 1'b0;
    logic [2:0] uart_addr = 3'd0;
    logic [7:0] uart_din = 8'h00;
    logic [7:0] uart_dout;
    logic       rx_data_present;
    logic       tx_full;
    logic       rxd = 1'b1;
    logic       txd;

    int total = 0;
    int bad   = 0;

    uart_mmio dut (
        .clk             (clk),
        .rst             (rst),
        .tx_wen          (tx_wen),
        .rx_ren          (rx_ren),
        .uart_addr       (uart_addr),
        .uart_din        (uart_din),
        .uart_dout       (uart_dout),
        .rx_data_present (rx_data_present),
        .tx_full         (tx_full),
        .rxd             (rxd),
        .txd             (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling clock edge.
    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        tx_wen = 1'b1; uart_addr = a; uart_din = d;
        @(negedge clk);
        tx_wen = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [7:0] d);
        rx_ren = 1'b1; uart_addr = a;
        #1 d = uart_dout;
        @(negedge clk);
        rx_ren = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        uart_addr = a;
        #1 d = uart_dout;
    endtask

    task automatic set_div(input int d);
        do_write(3'd3, 8'(d >> 8));
        do_write(3'd2, 8'(d));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int eff(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // Line level at each clock of one 8N1 frame: start, 8 data LSB-first, stop.
    function automatic logic [63:0] frame_wave(input logic [7:0] b, input int d);
        logic [63:0] w = '0;
        for (int k = 0; k < 10 * d; k++) begin
            int idx = k / d;
            if (idx == 0)      w[k] = 1'b0;
            else if (idx == 9) w[k] = 1'b1;
            else               w[k] = b[idx-1];
        end
        return w;
    endfunction

    task automatic capture(input int n, output logic [63:0] w);
        w = '0;
        for (int k = 0; k < n; k++) begin
            w[k] = txd;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int d, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      rxd = 1'b0;
            else if (i == 9) rxd = stop_bit;
            else             rxd = b[i-1];
            repeat (d) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic wait_rx(input int budget, input string tag);
        logic ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (rx_data_present) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    function automatic logic [7:0] status_model(input logic ovr, input logic busy,
                                                input logic txe, input logic txf,
                                                input logic rxp);
        return {3'b000, ovr, busy, txe, txf, rxp};
    endfunction

    logic [7:0]  rd;
    logic [7:0]  st;
    logic [63:0] w;
    logic [63:0] bz;
    logic [7:0]  txb [18];
    logic [7:0]  rx_q [$];
    logic        ovr_model;
    logic [7:0]  b;
    int          d;

    initial begin
        @(negedge clk);
        do_reset();

        // ---- reset state ----
        check("reset_txd", 64'(txd), 64'd1);
        check("reset_rxdp", 64'(rx_data_present), 64'd0);
        check("reset_txfull", 64'(tx_full), 64'd0);
        do_read(3'd1, rd); check("reset_status", 64'(rd), 64'h04);
        do_read(3'd2, rd); check("reset_div_lo", 64'(rd), 64'h64);
        do_read(3'd3, rd); check("reset_div_hi", 64'(rd), 64'h03);
        do_read(3'd0, rd); check("empty_data_read", 64'(rd), 64'h00);
        do_write(3'd4, 8'hFF);
        for (int a = 4; a < 8; a++) begin
            do_read(3'(a), rd); check($sformatf("unused_off%0d", a), 64'(rd), 64'h00);
        end

        // ---- single TX frame 0xA5 at div 4 ----
        set_div(4);
        do_write(3'd0, 8'hA5);
        check("tx_idle_on_push_cycle", 64'(txd), 64'd1);
        @(negedge clk);
        w = '0; bz = '0;
        for (int k = 0; k < 40; k++) begin
            w[k] = txd;
            peek(3'd1, st);
            bz[k] = st[3];
            @(negedge clk);
        end
        check("tx_a5_wave", w, frame_wave(8'hA5, 4));
        check("tx_a5_busy", bz, (64'd1 << 40) - 64'd1);
        peek(3'd1, st); check("tx_a5_idle_status", 64'(st), 64'h04);
        check("tx_a5_txd_idle", 64'(txd), 64'd1);

        // ---- back-to-back random TX, including divisor below minimum ----
        for (int r = 0; r < 2; r++) begin
            d = (r == 0) ? 1 : int'($urandom_range(3, 6));
            set_div(d);
            do_read(3'd2, rd); check("div_lo_readback", 64'(rd), 64'(d));
            for (int i = 0; i < 3; i++) txb[i] = 8'($urandom);
            fork
                begin
                    for (int i = 0; i < 3; i++) do_write(3'd0, txb[i]);
                end
                begin
                    logic seen = 1'b0;
                    logic [63:0] cw;
                    for (int t = 0; t < 10; t++) begin
                        if (txd == 1'b0) begin seen = 1'b1; break; end
                        @(negedge clk);
                    end
                    check("tx_b2b_start", 64'(seen), 64'd1);
                    for (int i = 0; i < 3; i++) begin
                        capture(10 * eff(d), cw);
                        check($sformatf("tx_b2b_r%0d_byte%0d", r, i), cw, frame_wave(txb[i], eff(d)));
                    end
                end
            join
            peek(3'd1, st); check("tx_b2b_idle_status", 64'(st), 64'h04);
        end

        // ---- RX single frame 0x3C at div 4 ----
        set_div(4);
        send_frame(8'h3C, 4, 1'b1);
        wait_rx(20, "rx_3c_arrive");
        do_read(3'd0, rd); check("rx_3c_data", 64'(rd), 64'h3C);
        check("rx_3c_popped", 64'(rx_data_present), 64'd0);

        // ---- simultaneous write and read at DATA: write wins, no pop ----
        send_frame(8'h5A, 4, 1'b1);
        wait_rx(20, "rx_5a_arrive");
        tx_wen = 1'b1; rx_ren = 1'b1; uart_addr = 3'd0; uart_din = 8'h00;
        @(negedge clk);
        tx_wen = 1'b0; rx_ren = 1'b0;
        check("rw_collision_no_pop", 64'(rx_data_present), 64'd1);
        do_read(3'd0, rd); check("rw_collision_data", 64'(rd), 64'h5A);
        repeat (50) @(negedge clk);

        // ---- 17 frames without reading: overrun ----
        ovr_model = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (rx_q.size() < 16) rx_q.push_back(b);
            else                  ovr_model = 1'b1;
            send_frame(b, 4, 1'b1);
        end
        repeat (10) @(negedge clk);
        do_read(3'd1, rd);
        check("ovr_status_first", 64'(rd), 64'(status_model(ovr_model, 1'b0, 1'b1, 1'b0, rx_q.size() > 0)));
        ovr_model = 1'b0;
        do_read(3'd1, rd);
        check("ovr_status_second", 64'(rd), 64'(status_model(ovr_model, 1'b0, 1'b1, 1'b0, rx_q.size() > 0)));
        while (rx_q.size() > 0) begin
            do_read(3'd0, rd);
            check("ovr_fifo_data", 64'(rd), 64'(rx_q.pop_front()));
        end
        check("ovr_drained", 64'(rx_data_present), 64'd0);
        do_read(3'd0, rd); check("ovr_empty_read", 64'(rd), 64'h00);

        // ---- glitch and framing error at div 8 ----
        set_div(8);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_byte", 64'(rx_data_present), 64'd0);
        send_frame(8'($urandom), 8, 1'b0);
        repeat (40) @(negedge clk);
        check("framing_discard", 64'(rx_data_present), 64'd0);
        peek(3'd1, st); check("framing_no_overrun", 64'(st[4]), 64'd0);
        b = 8'($urandom);
        send_frame(b, 8, 1'b1);
        wait_rx(30, "post_framing_arrive");
        do_read(3'd0, rd); check("post_framing_data", 64'(rd), 64'(b));

        // ---- TX FIFO full at default divisor ----
        do_reset();
        for (int i = 0; i < 18; i++) txb[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) do_write(3'd0, txb[i]);
        check("txfifo_15_not_full", 64'(tx_full), 64'd0);
        do_write(3'd0, txb[16]);
        check("txfifo_16_full", 64'(tx_full), 64'd1);
        peek(3'd1, st); check("txfifo_full_status", 64'(st), 64'h0A);
        do_write(3'd0, txb[17]);
        check("txfifo_18th_full", 64'(tx_full), 64'd1);
        // Shrinking the divisor restarts the current start bit's timing.
        set_div(2);
        for (int i = 0; i < 17; i++) begin
            capture(20, w);
            check($sformatf("txfifo_drain_byte%0d", i), w, frame_wave(txb[i], 2));
        end
        peek(3'd1, st); check("txfifo_drained_status", 64'(st), 64'h04);

        // ---- reset mid-frame ----
        set_div(4);
        do_write(3'd0, 8'h0F);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        check("midframe_txd_low", 64'(txd), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_txd", 64'(txd), 64'd1);
        rst = 1'b0;
        rxd = 1'b1;
        repeat (60) @(negedge clk);
        check("midframe_rxdp", 64'(rx_data_present), 64'd0);
        check("midframe_txd_idle", 64'(txd), 64'd1);
        peek(3'd1, st); check("midframe_status", 64'(st), 64'h04);
        do_read(3'd2, rd); check("midframe_div_lo", 64'(rd), 64'h64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
